pwr_inrush_arbiter: RTL and testbench

//  Arbitrates power-enable requests from NUM_REQ rail channels (N1, N2, NIC0, NIC1, ...) sharing the P12V/P48V inrush budget.

---
 rtl/pwr_inrush_arbiter.sv | 151 +++++++++++++++
 tb/tb_pwr_inrush_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwr_inrush_arbiter.sv
// Round-robin inrush arbiter: one rail ramps at a time, PWRGD/timeout ends the ramp, then a settle gap.
// Latency: request to enable one cycle; no backpressure, requests are levels held until served or dropped.
module pwr_inrush_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int TMR_W      = 16,
    parameter int PG_TIMEOUT = 1000,
    parameter int GAP_TIME   = 20
) (
    input  logic               iClk,
    input  logic               iRst_n,
    input  logic               iTick_1ms,
    input  logic [NUM_REQ-1:0] iReq,
    input  logic [NUM_REQ-1:0] iPwrgd,
    input  logic               iAbort,
    input  logic               iFault_clr,
    output logic [NUM_REQ-1:0] oEn,
    output logic               oGrant_vld,
    output logic [2:0]         oGrant_idx,
    output logic [NUM_REQ-1:0] oFault,
    output logic               oBusy,
    output logic [1:0]         oState
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [NUM_REQ-1:0] r_en, w_en_nxt;
    logic [NUM_REQ-1:0] r_fault, w_fault_nxt;
    logic               r_grant_vld, w_grant_vld_nxt;
    logic [IW-1:0]      r_idx, w_idx_nxt;
    logic [IW-1:0]      r_ptr, w_ptr_nxt;
    logic [TMR_W-1:0]   r_timer, w_timer_nxt;
    logic               r_busy;

    logic [NUM_REQ-1:0] w_elig;
    logic               w_any;
    logic [IW-1:0]      w_pick;
    logic [TMR_W-1:0]   w_timer_inc;

    assign w_elig      = iReq & ~r_en & ~r_fault;
    assign w_timer_inc = (r_timer == {TMR_W{1'b1}}) ? r_timer : r_timer + 1'b1;

    // First eligible channel scanning upward from the round-robin pointer
    always_comb begin
        int j;
        j      = 0;
        w_any  = 1'b0;
        w_pick = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(r_ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!w_any && w_elig[j]) begin
                w_any  = 1'b1;
                w_pick = IW'(j);
            end
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_en_nxt        = r_en & iReq;   // released rails drop regardless of state
        w_fault_nxt     = iFault_clr ? '0 : r_fault;
        w_grant_vld_nxt = r_grant_vld;
        w_idx_nxt       = r_idx;
        w_ptr_nxt       = r_ptr;
        w_timer_nxt     = r_timer;

        if (iAbort) begin
            w_state_nxt     = ST_IDLE;
            w_en_nxt        = '0;
            w_grant_vld_nxt = 1'b0;
            w_timer_nxt     = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        w_en_nxt[w_pick] = 1'b1;
                        w_grant_vld_nxt  = 1'b1;
                        w_idx_nxt        = w_pick;
                        w_timer_nxt      = '0;
                        w_ptr_nxt        = (w_pick == IW'(NUM_REQ - 1)) ? '0 : w_pick + 1'b1;
                        w_state_nxt      = ST_RAMP;
                    end
                end
                ST_RAMP: begin
                    // Request drop outranks PWRGD, which outranks the timeout
                    if (!iReq[r_idx] || iPwrgd[r_idx]) begin
                        w_grant_vld_nxt = 1'b0;
                        w_timer_nxt     = '0;
                        w_state_nxt     = ST_GAP;
                    end else if (iTick_1ms && (w_timer_inc == TMR_W'(PG_TIMEOUT))) begin
                        w_fault_nxt[r_idx] = 1'b1;
                        w_en_nxt[r_idx]    = 1'b0;
                        w_grant_vld_nxt    = 1'b0;
                        w_timer_nxt        = '0;
                        w_state_nxt        = ST_GAP;
                    end else if (iTick_1ms) begin
                        w_timer_nxt = w_timer_inc;
                    end
                end
                ST_GAP: begin
                    if (r_timer == TMR_W'(GAP_TIME)) begin
                        w_timer_nxt = '0;
                        w_state_nxt = ST_IDLE;
                    end else if (iTick_1ms) begin
                        w_timer_nxt = w_timer_inc;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_timer_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_state     <= ST_IDLE;
            r_en        <= '0;
            r_fault     <= '0;
            r_grant_vld <= 1'b0;
            r_idx       <= '0;
            r_ptr       <= '0;
            r_timer     <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_en        <= w_en_nxt;
            r_fault     <= w_fault_nxt;
            r_grant_vld <= w_grant_vld_nxt;
            r_idx       <= w_idx_nxt;
            r_ptr       <= w_ptr_nxt;
            r_timer     <= w_timer_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
        end
    end

    assign oEn        = r_en;
    assign oFault     = r_fault;
    assign oGrant_vld = r_grant_vld;
    assign oGrant_idx = 3'(r_idx);
    assign oBusy      = r_busy;
    assign oState     = r_state;

endmodule

// File: tb/tb_pwr_inrush_arbiter.sv
// Directed bench for pwr_inrush_arbiter: inputs change and outputs are sampled 1ns after each rising edge.
// One simulated millisecond is two clocks with the tick pulse high for the first.
module tb_pwr_inrush_arbiter;
    logic       iClk = 1'b0;
    logic       iRst_n = 1'b0;
    logic       iTick_1ms = 1'b0;
    logic [3:0] iReq = '0;
    logic [3:0] iPwrgd = '0;
    logic       iAbort = 1'b0;
    logic       iFault_clr = 1'b0;
    logic [3:0] oEn;
    logic       oGrant_vld;
    logic [2:0] oGrant_idx;
    logic [3:0] oFault;
    logic       oBusy;
    logic [1:0] oState;

    int n_vec = 0;
    int n_err = 0;

    pwr_inrush_arbiter #(.NUM_REQ(4), .TMR_W(16), .PG_TIMEOUT(1000), .GAP_TIME(20)) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iTick_1ms(iTick_1ms), .iReq(iReq), .iPwrgd(iPwrgd),
        .iAbort(iAbort), .iFault_clr(iFault_clr), .oEn(oEn), .oGrant_vld(oGrant_vld),
        .oGrant_idx(oGrant_idx), .oFault(oFault), .oBusy(oBusy), .oState(oState)
    );

    always #5 iClk = ~iClk;

    task automatic cyc();
        @(posedge iClk);
        #1;
    endtask

    task automatic ms(input int n);
        for (int i = 0; i < n; i++) begin
            iTick_1ms = 1'b1;
            cyc();
            iTick_1ms = 1'b0;
            cyc();
        end
    endtask

    task automatic test_reset();
        iRst_n = 1'b0;
        cyc(); cyc();
        n_vec++; if (oEn !== 4'b0000) begin n_err++; $display("FAIL rst_en got=%b exp=0000", oEn); end
        n_vec++; if (oFault !== 4'b0000) begin n_err++; $display("FAIL rst_fault got=%b exp=0000", oFault); end
        n_vec++; if ({oGrant_vld, oGrant_idx} !== 4'd0) begin n_err++; $display("FAIL rst_grant got=%b/%0d exp=0/0", oGrant_vld, oGrant_idx); end
        n_vec++; if ({oBusy, oState} !== 3'd0) begin n_err++; $display("FAIL rst_state got busy=%b st=%0d exp=0/0", oBusy, oState); end
        iRst_n = 1'b1;
        cyc();
    endtask

    task automatic test_sequence();
        iReq = 4'b0011;
        cyc();
        n_vec++; if (oEn !== 4'b0001) begin n_err++; $display("FAIL seq_en0 got=%b exp=0001", oEn); end
        n_vec++; if ({oGrant_vld, oGrant_idx, oState, oBusy} !== {1'b1, 3'd0, 2'd1, 1'b1}) begin
            n_err++; $display("FAIL seq_grant0 got vld=%b idx=%0d st=%0d busy=%b exp 1/0/1/1", oGrant_vld, oGrant_idx, oState, oBusy); end
        ms(5);
        n_vec++; if ({oState, oEn} !== {2'd1, 4'b0001}) begin n_err++; $display("FAIL seq_ramp5 got st=%0d en=%b exp 1/0001", oState, oEn); end
        iPwrgd = 4'b0001;
        cyc();
        n_vec++; if ({oState, oGrant_vld, oEn} !== {2'd2, 1'b0, 4'b0001}) begin
            n_err++; $display("FAIL seq_gap got st=%0d vld=%b en=%b exp 2/0/0001", oState, oGrant_vld, oEn); end
        ms(19);
        n_vec++; if ({oState, oEn} !== {2'd2, 4'b0001}) begin n_err++; $display("FAIL seq_gap19 got st=%0d en=%b exp 2/0001", oState, oEn); end
        ms(1);
        n_vec++; if ({oState, oEn} !== {2'd0, 4'b0001}) begin n_err++; $display("FAIL seq_idle got st=%0d en=%b exp 0/0001", oState, oEn); end
        cyc();
        n_vec++; if ({oEn, oGrant_idx, oGrant_vld} !== {4'b0011, 3'd1, 1'b1}) begin
            n_err++; $display("FAIL seq_en1 got en=%b idx=%0d vld=%b exp 0011/1/1", oEn, oGrant_idx, oGrant_vld); end
        iPwrgd = 4'b0011;
        cyc();
        ms(20);
        n_vec++; if ({oState, oFault, oEn} !== {2'd0, 4'b0000, 4'b0011}) begin
            n_err++; $display("FAIL seq_done got st=%0d fault=%b en=%b exp 0/0000/0011", oState, oFault, oEn); end
        iReq = 4'b0000; iPwrgd = 4'b0000;
        cyc();
        n_vec++; if (oEn !== 4'b0000) begin n_err++; $display("FAIL seq_release got=%b exp=0000", oEn); end
    endtask

    task automatic test_timeout();
        iReq = 4'b0100;
        cyc();
        n_vec++; if ({oEn, oGrant_idx} !== {4'b0100, 3'd2}) begin n_err++; $display("FAIL to_grant got en=%b idx=%0d exp 0100/2", oEn, oGrant_idx); end
        ms(999);
        n_vec++; if ({oFault, oEn, oState} !== {4'b0000, 4'b0100, 2'd1}) begin
            n_err++; $display("FAIL to_999 got fault=%b en=%b st=%0d exp 0000/0100/1", oFault, oEn, oState); end
        iTick_1ms = 1'b1;
        cyc();
        iTick_1ms = 1'b0;
        n_vec++; if ({oFault, oEn, oState, oGrant_vld} !== {4'b0100, 4'b0000, 2'd2, 1'b0}) begin
            n_err++; $display("FAIL to_1000 got fault=%b en=%b st=%0d vld=%b exp 0100/0000/2/0", oFault, oEn, oState, oGrant_vld); end
        ms(20);
        cyc(); cyc(); cyc();
        n_vec++; if ({oEn, oState, oFault} !== {4'b0000, 2'd0, 4'b0100}) begin
            n_err++; $display("FAIL to_ignored got en=%b st=%0d fault=%b exp 0000/0/0100", oEn, oState, oFault); end
        iFault_clr = 1'b1;
        cyc();
        iFault_clr = 1'b0;
        n_vec++; if ({oFault, oEn} !== {4'b0000, 4'b0000}) begin n_err++; $display("FAIL to_clr got fault=%b en=%b exp 0000/0000", oFault, oEn); end
        cyc();
        n_vec++; if ({oEn, oGrant_idx} !== {4'b0100, 3'd2}) begin n_err++; $display("FAIL to_regrant got en=%b idx=%0d exp 0100/2", oEn, oGrant_idx); end
        iPwrgd = 4'b0100;
        cyc();
        ms(20);
        iReq = 4'b0000; iPwrgd = 4'b0000;
        cyc();
    endtask

    task automatic test_round_robin();
        iReq = 4'b0010;
        cyc();
        n_vec++; if ({oEn, oGrant_idx} !== {4'b0010, 3'd1}) begin n_err++; $display("FAIL rr_ch1 got en=%b idx=%0d exp 0010/1", oEn, oGrant_idx); end
        iPwrgd = 4'b0010;
        cyc();
        ms(20);
        iReq = 4'b1111;
        cyc();
        n_vec++; if ({oEn, oGrant_idx} !== {4'b0110, 3'd2}) begin n_err++; $display("FAIL rr_ch2 got en=%b idx=%0d exp 0110/2", oEn, oGrant_idx); end
        iPwrgd = 4'b0110;
        cyc();
        ms(20);
        cyc();
        n_vec++; if ({oEn, oGrant_idx} !== {4'b1110, 3'd3}) begin n_err++; $display("FAIL rr_ch3 got en=%b idx=%0d exp 1110/3", oEn, oGrant_idx); end
        iPwrgd = 4'b1110;
        cyc();
        ms(20);
        cyc();
        n_vec++; if ({oEn, oGrant_idx} !== {4'b1111, 3'd0}) begin n_err++; $display("FAIL rr_ch0 got en=%b idx=%0d exp 1111/0", oEn, oGrant_idx); end
        iPwrgd = 4'b1111;
        cyc();
        ms(20);
        iReq = 4'b0000; iPwrgd = 4'b0000;
        cyc();
    endtask

    task automatic test_abort();
        iReq = 4'b0111; iPwrgd = 4'b0111;
        cyc(); cyc(); ms(20);
        cyc(); cyc(); ms(20);
        cyc();
        n_vec++; if ({oEn, oGrant_idx} !== {4'b0111, 3'd0}) begin n_err++; $display("FAIL ab_setup got en=%b idx=%0d exp 0111/0", oEn, oGrant_idx); end
        cyc(); ms(20);
        iReq = 4'b1111;
        cyc();
        n_vec++; if ({oEn, oGrant_idx, oState} !== {4'b1111, 3'd3, 2'd1}) begin
            n_err++; $display("FAIL ab_ramp3 got en=%b idx=%0d st=%0d exp 1111/3/1", oEn, oGrant_idx, oState); end
        iAbort = 1'b1;
        cyc();
        n_vec++; if ({oEn, oState, oGrant_vld, oBusy, oFault} !== {4'b0000, 2'd0, 1'b0, 1'b0, 4'b0000}) begin
            n_err++; $display("FAIL ab_drop got en=%b st=%0d vld=%b busy=%b fault=%b exp 0000/0/0/0/0000", oEn, oState, oGrant_vld, oBusy, oFault); end
        cyc(); cyc(); cyc();
        n_vec++; if ({oEn, oGrant_vld, oState} !== {4'b0000, 1'b0, 2'd0}) begin
            n_err++; $display("FAIL ab_block got en=%b vld=%b st=%0d exp 0000/0/0", oEn, oGrant_vld, oState); end
        iAbort = 1'b0;
        cyc();
        n_vec++; if ({oEn, oGrant_idx} !== {4'b0001, 3'd0}) begin n_err++; $display("FAIL ab_resume got en=%b idx=%0d exp 0001/0", oEn, oGrant_idx); end
        iPwrgd = 4'b1111;
        cyc();
        iReq = 4'b0000;
        cyc();
        ms(20);
        iPwrgd = 4'b0000;
    endtask

    task automatic test_drop_and_clr();
        iReq = 4'b0010;
        cyc();
        n_vec++; if ({oEn, oGrant_idx} !== {4'b0010, 3'd1}) begin n_err++; $display("FAIL dr_grant got en=%b idx=%0d exp 0010/1", oEn, oGrant_idx); end
        iReq = 4'b0000; iPwrgd = 4'b0010;
        cyc();
        n_vec++; if ({oEn, oFault, oState, oGrant_vld} !== {4'b0000, 4'b0000, 2'd2, 1'b0}) begin
            n_err++; $display("FAIL dr_drop got en=%b fault=%b st=%0d vld=%b exp 0000/0000/2/0", oEn, oFault, oState, oGrant_vld); end
        iPwrgd = 4'b0000;
        ms(20);
        iReq = 4'b0100;
        cyc();
        n_vec++; if ({oEn, oGrant_idx} !== {4'b0100, 3'd2}) begin n_err++; $display("FAIL dr_grant2 got en=%b idx=%0d exp 0100/2", oEn, oGrant_idx); end
        ms(999);
        iTick_1ms = 1'b1; iFault_clr = 1'b1;
        cyc();
        iTick_1ms = 1'b0; iFault_clr = 1'b0;
        n_vec++; if ({oFault, oEn} !== {4'b0100, 4'b0000}) begin n_err++; $display("FAIL dr_setwins got fault=%b en=%b exp 0100/0000", oFault, oEn); end
        iReq = 4'b0000; iFault_clr = 1'b1;
        cyc();
        iFault_clr = 1'b0;
        n_vec++; if (oFault !== 4'b0000) begin n_err++; $display("FAIL dr_clr got=%b exp=0000", oFault); end
        ms(20);
    endtask

    task automatic test_reset_mid();
        iReq = 4'b0010; iPwrgd = 4'b0011;
        cyc();
        cyc();
        iReq = 4'b0011;
        ms(20);
        cyc();
        n_vec++; if ({oEn, oGrant_idx} !== {4'b0011, 3'd0}) begin n_err++; $display("FAIL rm_setup got en=%b idx=%0d exp 0011/0", oEn, oGrant_idx); end
        cyc();
        ms(3);
        n_vec++; if ({oEn, oState} !== {4'b0011, 2'd2}) begin n_err++; $display("FAIL rm_gap got en=%b st=%0d exp 0011/2", oEn, oState); end
        iRst_n = 1'b0;
        cyc();
        n_vec++; if ({oEn, oFault, oGrant_vld, oGrant_idx, oBusy, oState} !== 15'd0) begin
            n_err++; $display("FAIL rm_reset got en=%b fault=%b vld=%b idx=%0d busy=%b st=%0d exp all 0", oEn, oFault, oGrant_vld, oGrant_idx, oBusy, oState); end
        iRst_n = 1'b1; iPwrgd = 4'b0000;
        cyc();
        n_vec++; if ({oEn, oGrant_idx, oState} !== {4'b0001, 3'd0, 2'd1}) begin
            n_err++; $display("FAIL rm_ptr0 got en=%b idx=%0d st=%0d exp 0001/0/1", oEn, oGrant_idx, oState); end
        ms(10);
        iRst_n = 1'b0;
        cyc();
        n_vec++; if ({oEn, oFault, oState} !== {4'b0000, 4'b0000, 2'd0}) begin
            n_err++; $display("FAIL rm_ramp_rst got en=%b fault=%b st=%0d exp 0000/0000/0", oEn, oFault, oState); end
        iRst_n = 1'b1; iReq = 4'b0000;
        cyc();
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_timeout();
        test_round_robin();
        test_abort();
        test_drop_and_clr();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
